// File: rtl/uart_frame_encoder.sv
// UART TX framer: snapshots game status and card slots, then streams SOF, STATUS, CARD[0..N-1], CSUM into the TX FIFO.
// Defining UART_FRAME_SEQ_EN inserts an 8-bit sequence byte after SOF, covered by the checksum.
module uart_frame_encoder #(
  parameter int         N_CARDS        = 9,
  parameter int         CARD_W         = 4,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         REFRESH_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_full,
  input  logic                        start,
  input  logic                        deal,
  input  logic                        dealer_finished,
  input  logic [N_CARDS*CARD_W-1:0]   card_values,
  output logic                        wr_uart,
  output logic [7:0]                  w_data,
  output logic                        busy
);

  localparam int IW = 8 - CARD_W;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = (REFRESH_CYCLES > 0) ? RW'(REFRESH_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CARDS - 1);

`ifdef UART_FRAME_SEQ_EN
  typedef enum logic [2:0] {IDLE, SOF, SEQ, STATUS, CARD, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, SOF, STATUS, CARD, CSUM} state_t;
`endif

  state_t                      state, state_n;
  logic                        wr_n, busy_n;
  logic [7:0]                  data_n;
  logic [2:0]                  snap_status, snap_status_n;
  logic [N_CARDS*CARD_W-1:0]   snap_cards, snap_cards_n;
  logic                        sent_valid, sent_valid_n;
  logic [RW-1:0]               refresh_cnt, refresh_n;
  logic [IW-1:0]               idx, idx_n;
  logic [7:0]                  csum, csum_n;
  logic [2:0]                  live_status;
  logic                        changed, refresh_hit, can_issue;
  logic [7:0]                  status_byte, card_byte;
`ifdef UART_FRAME_SEQ_EN
  logic [7:0]                  seq_cnt, seq_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_uart     <= 1'b0;
      w_data      <= 8'h00;
      busy        <= 1'b0;
      snap_status <= '0;
      snap_cards  <= '0;
      sent_valid  <= 1'b0;
      refresh_cnt <= '0;
      idx         <= '0;
      csum        <= '0;
`ifdef UART_FRAME_SEQ_EN
      seq_cnt     <= '0;
`endif
    end else begin
      state       <= state_n;
      wr_uart     <= wr_n;
      w_data      <= data_n;
      busy        <= busy_n;
      snap_status <= snap_status_n;
      snap_cards  <= snap_cards_n;
      sent_valid  <= sent_valid_n;
      refresh_cnt <= refresh_n;
      idx         <= idx_n;
      csum        <= csum_n;
`ifdef UART_FRAME_SEQ_EN
      seq_cnt     <= seq_n;
`endif
    end
  end

  always_comb begin
    state_n       = state;
    wr_n          = 1'b0;
    data_n        = w_data;
    snap_status_n = snap_status;
    snap_cards_n  = snap_cards;
    sent_valid_n  = sent_valid;
    refresh_n     = refresh_cnt;
    idx_n         = idx;
    csum_n        = csum;
`ifdef UART_FRAME_SEQ_EN
    seq_n         = seq_cnt;
`endif

    live_status = {start, deal, dealer_finished};
    changed     = {live_status, card_values} != {snap_status, snap_cards};
    refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt == REFRESH_LAST);
    // Gap after every write lets a one-cycle-late tx_full take effect before the next byte.
    can_issue   = !tx_full && !wr_uart;
    status_byte = {1'b0, snap_status, 4'h0};
    card_byte   = {snap_cards[int'(idx)*CARD_W +: CARD_W], idx};

    case (state)
      IDLE: begin
        if (!sent_valid || changed || refresh_hit) begin
          state_n       = SOF;
          snap_status_n = live_status;
          snap_cards_n  = card_values;
          sent_valid_n  = 1'b1;
          refresh_n     = '0;
          idx_n         = '0;
          csum_n        = '0;
        end else if ((REFRESH_CYCLES > 0) && (refresh_cnt != REFRESH_LAST)) begin
          refresh_n = refresh_cnt + RW'(1);
        end
      end
      SOF: begin
        if (can_issue) begin
          wr_n   = 1'b1;
          data_n = SOF_BYTE;
`ifdef UART_FRAME_SEQ_EN
          state_n = SEQ;
`else
          state_n = STATUS;
`endif
        end
      end
`ifdef UART_FRAME_SEQ_EN
      SEQ: begin
        if (can_issue) begin
          wr_n    = 1'b1;
          data_n  = seq_cnt;
          csum_n  = csum ^ seq_cnt;
          state_n = STATUS;
        end
      end
`endif
      STATUS: begin
        if (can_issue) begin
          wr_n    = 1'b1;
          data_n  = status_byte;
          csum_n  = csum ^ status_byte;
          state_n = CARD;
        end
      end
      CARD: begin
        if (can_issue) begin
          wr_n   = 1'b1;
          data_n = card_byte;
          csum_n = csum ^ card_byte;
          if (idx == LAST_IDX) begin
            state_n = CSUM;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      CSUM: begin
        if (can_issue) begin
          wr_n    = 1'b1;
          data_n  = csum;
          state_n = IDLE;
`ifdef UART_FRAME_SEQ_EN
          seq_n   = seq_cnt + 8'd1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // Held through the CSUM write so busy drops only once the last byte is out.
    busy_n = (state_n != IDLE) || wr_n;
  end

endmodule

// File: tb/tb_uart_frame_encoder.sv
// Scoreboard bench for uart_frame_encoder: stimulus pushes expected bytes, a negedge monitor pops and compares.
// Handles both builds (UART_FRAME_SEQ_EN defined or not).
module tb_uart_frame_encoder;
  localparam int N   = 9;
  localparam int W   = 4;
  localparam int REF = 50;
`ifdef UART_FRAME_SEQ_EN
  localparam int FL  = 13;
`else
  localparam int FL  = 12;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tx_full = 1'b0;
  logic           start = 1'b0;
  logic           deal = 1'b0;
  logic           dealer_finished = 1'b0;
  logic [N*W-1:0] card_values = '0;
  logic           wr_uart;
  logic [7:0]     w_data;
  logic           busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         cyc = 0;
  int         pops = 0;
  int         last_pop_cyc = 0;
  logic       prev_wr = 1'b0;
  logic [7:0] seq = 8'h00;
  int         base, mark, p0;

  logic [7:0] f0_lit [12] = '{8'hA5, 8'h40, 8'h00, 8'h01, 8'h02, 8'h03,
                              8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h48};
  logic [7:0] f1_lit [12] = '{8'hA5, 8'h40, 8'h00, 8'h01, 8'hA2, 8'h03,
                              8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hE8};

  uart_frame_encoder #(
    .N_CARDS(N),
    .CARD_W(W),
    .SOF_BYTE(8'hA5),
    .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_full(tx_full),
    .start(start),
    .deal(deal),
    .dealer_finished(dealer_finished),
    .card_values(card_values),
    .wr_uart(wr_uart),
    .w_data(w_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && wr_uart) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, required no write", w_data);
      end else begin
        exp_b = sb.pop_front();
        if (w_data !== exp_b) begin
          errors++;
          $display("FAIL byte_%0d: got %02h, required %02h", pops, w_data, exp_b);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_write: got %b, required 1", busy);
      end
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL back_to_back_write: got consecutive strobes, required gap");
      end
      pops++;
      last_pop_cyc = cyc;
    end
    prev_wr = wr_uart;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push_frame(input logic [2:0] st, input logic [N*W-1:0] cv);
    logic [7:0] cs, b;
    sb.push_back(8'hA5);
    cs = 8'h00;
`ifdef UART_FRAME_SEQ_EN
    sb.push_back(seq);
    cs = seq;
    seq = seq + 8'd1;
`endif
    b = {1'b0, st, 4'h0};
    sb.push_back(b);
    cs ^= b;
    for (int i = 0; i < N; i++) begin
      b = {cv[i*W +: W], 4'(i)};
      sb.push_back(b);
      cs ^= b;
    end
    sb.push_back(cs);
  endtask

  task automatic push_fixed(input int which);
`ifdef UART_FRAME_SEQ_EN
    logic [N*W-1:0] cv;
    cv = '0;
    if (which == 1) cv[2*W +: W] = 4'hA;
    push_frame(3'b100, cv);
`else
    for (int i = 0; i < 12; i++) sb.push_back(which == 1 ? f1_lit[i] : f0_lit[i]);
`endif
  endtask

  task automatic wait_pops(input int target, input string what);
    int n;
    n = 0;
    while (pops < target && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (pops < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", what, pops, target);
    end
  endtask

  task automatic drain(input string what);
    wait_pops(pops + sb.size(), what);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_uart", wr_uart, 0);
    chk("rst_w_data", w_data, 8'h00);
    chk("rst_busy", busy, 0);

    // Frame forced after reset
    start = 1'b1;
    push_fixed(0);
    rst = 1'b0;
    drain("first_frame");
    @(negedge clk);
    #1;
    chk("busy_low_after_frame", busy, 0);

    // Refresh of an unchanged frame: 50 IDLE cycles, then SOF, then the SOF write
    mark = last_pop_cyc;
    push_fixed(0);
    base = pops;
    wait_pops(base + 1, "refresh_sof");
    chk("refresh_gap", last_pop_cyc - mark, 51);
    drain("refresh_frame");

    // Change card 2 mid-frame: current frame intact, next frame follows immediately
    push_fixed(0);
    base = pops;
    wait_pops(base + 1, "midchange_sof");
    card_values[2*W +: W] = 4'hA;
    push_fixed(1);
    wait_pops(base + FL, "midchange_old");
    mark = last_pop_cyc;
    wait_pops(base + FL + 1, "midchange_new_sof");
    chk("change_restart_gap", last_pop_cyc - mark, 2);
    drain("midchange_new");
    @(negedge clk);
    #1;
    chk("busy_low_after_change", busy, 0);

    // tx_full stall after STATUS
    push_frame(3'b100, card_values);
    base = pops;
    wait_pops(base + FL - 10, "stall_status");
    tx_full = 1'b1;
    p0 = pops;
    repeat (20) @(negedge clk);
    #1;
    chk("writes_during_full", pops - p0, 0);
    tx_full = 1'b0;
    drain("stall_resume");
    chk("stall_frame_len", pops - base, FL);

    // Reset while in CARD[4]
    push_frame(3'b100, card_values);
    base = pops;
    wait_pops(base + FL - 6, "abort_card3");
    sb.delete();
    rst = 1'b1;
    #1;
    chk("abort_wr_uart", wr_uart, 0);
    chk("abort_w_data", w_data, 8'h00);
    chk("abort_busy", busy, 0);
    seq = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    push_frame(3'b100, card_values);
    base = pops;
    rst = 1'b0;
    drain("post_abort_frame");
    chk("post_abort_len", pops - base, FL);
    @(negedge clk);
    #1;
    chk("busy_low_final", busy, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule
